// File: rtl/axi_lite_to_cmd_unit_pkg.sv
// ---------------------------------------------------------------
// axi_lite_to_cmd_unit_pkg: response codes and FSM encodings. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package axi_lite_to_cmd_unit_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int unsigned DEF_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_ISSUE = 2'd1,
    W_WAIT  = 2'd2,
    W_RESP  = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_WAIT  = 2'd2,
    R_RESP  = 2'd3
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_lite_to_cmd_unit_cmd_wait_timer.sv
// ---------------------------------------------------------------
// axi_lite_to_cmd_unit_cmd_wait_timer: loadable down-counter with expiry
// flag; only built with AXI_CMD_TIMEOUT_EN. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

`ifdef AXI_CMD_TIMEOUT_EN
module axi_lite_to_cmd_unit_cmd_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Loaded with N-1 so the count reaches zero on the Nth waiting cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(TIMEOUT_CYC - 1);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule
`endif

`default_nettype wire

// File: rtl/axi_lite_to_cmd_unit.sv
// ---------------------------------------------------------------
// axi_lite_to_cmd_unit: AXI4-Lite slave to command-bus strobe bridge.
// Optional macro: AXI_CMD_TIMEOUT_EN (WAIT timeout -> SLVERR). Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module axi_lite_to_cmd_unit
  import axi_lite_to_cmd_unit_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [ADDR_W-1:0]   wr_addr_out,
  output logic [DATA_W-1:0]   wr_data_out,
  output logic [DATA_W/8-1:0] wr_strb_out,
  output logic                wr_enable_out,
  input  logic                wr_done_in,
  output logic [ADDR_W-1:0]   rd_addr_out,
  output logic                rd_enable_out,
  input  logic [DATA_W-1:0]   rd_data_in,
  input  logic                rd_done_in,
  output logic                wr_busy_out,
  output logic                rd_busy_out
);

  localparam int unsigned STRB_W = DATA_W / 8;

  wr_state_e           w_state_q, w_state_d;
  rd_state_e           r_state_q, r_state_d;
  logic                ready_en_q;
  logic                aw_have_q, w_have_q;
  logic [ADDR_W-1:0]   wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0]   wr_data_q, rdata_q;
  logic [STRB_W-1:0]   wr_strb_q;
  logic [1:0]          bresp_q, rresp_q;
  logic                aw_fire, w_fire, ar_fire;
  logic                wr_grant, rd_grant;
  logic                wr_expired, rd_expired;

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid  && s_axi_wready;
  assign ar_fire = s_axi_arvalid && s_axi_arready;

  // A channel holds the command bus from its grant until its response handshake;
  // a simultaneous request pair goes to the write side.
  assign wr_grant = (w_state_q == W_ISSUE) &&
                    (r_state_q != R_WAIT) && (r_state_q != R_RESP);
  assign rd_grant = (r_state_q == R_ISSUE) && (w_state_q == W_IDLE);

`ifdef AXI_CMD_TIMEOUT_EN
  logic wr_tmr_exp, rd_tmr_exp;

  axi_lite_to_cmd_unit_cmd_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wr_timer (
    .clk_i     (sys_clk),
    .rst_ni    (reset_n),
    .load_i    (wr_grant),
    .run_i     (w_state_q == W_WAIT),
    .expired_o (wr_tmr_exp)
  );

  axi_lite_to_cmd_unit_cmd_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rd_timer (
    .clk_i     (sys_clk),
    .rst_ni    (reset_n),
    .load_i    (rd_grant),
    .run_i     (r_state_q == R_WAIT),
    .expired_o (rd_tmr_exp)
  );

  assign wr_expired = (w_state_q == W_WAIT) && wr_tmr_exp;
  assign rd_expired = (r_state_q == R_WAIT) && rd_tmr_exp;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);
  assign wr_expired       = 1'b0;
  assign rd_expired       = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      ready_en_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if ((aw_have_q || aw_fire) && (w_have_q || w_fire)) w_state_d = W_ISSUE;
      W_ISSUE: if (wr_grant) w_state_d = W_WAIT;
      W_WAIT:  if (wr_done_in || wr_expired) w_state_d = W_RESP;
      W_RESP:  if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_fire) r_state_d = R_ISSUE;
      R_ISSUE: if (rd_grant) r_state_d = R_WAIT;
      R_WAIT:  if (rd_done_in || rd_expired) r_state_d = R_RESP;
      R_RESP:  if (s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = ready_en_q && (w_state_q == W_IDLE) && !aw_have_q;
    s_axi_wready  = ready_en_q && (w_state_q == W_IDLE) && !w_have_q;
    s_axi_arready = ready_en_q && (r_state_q == R_IDLE);
    s_axi_bvalid  = (w_state_q == W_RESP);
    s_axi_rvalid  = (r_state_q == R_RESP);
    s_axi_bresp   = bresp_q;
    s_axi_rresp   = rresp_q;
    s_axi_rdata   = rdata_q;
    wr_enable_out = wr_grant;
    rd_enable_out = rd_grant;
    wr_addr_out   = wr_addr_q;
    wr_data_out   = wr_data_q;
    wr_strb_out   = wr_strb_q;
    rd_addr_out   = rd_addr_q;
    wr_busy_out   = wr_grant || (w_state_q == W_WAIT) || (w_state_q == W_RESP);
    rd_busy_out   = rd_grant || (r_state_q == R_WAIT) || (r_state_q == R_RESP);
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_have_q <= 1'b1;
        wr_addr_q <= s_axi_awaddr;
      end
      if (w_fire) begin
        w_have_q  <= 1'b1;
        wr_data_q <= s_axi_wdata;
        wr_strb_q <= s_axi_wstrb;
      end
      if (w_state_q == W_ISSUE) begin
        aw_have_q <= 1'b0;
        w_have_q  <= 1'b0;
      end
      // Done takes priority over a timeout expiring in the same cycle.
      if (w_state_q == W_WAIT) begin
        if (wr_done_in)      bresp_q <= AXI_RESP_OKAY;
        else if (wr_expired) bresp_q <= AXI_RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
    end else begin
      if (ar_fire) rd_addr_q <= s_axi_araddr;
      if (r_state_q == R_WAIT) begin
        if (rd_done_in) begin
          rdata_q <= rd_data_in;
          rresp_q <= AXI_RESP_OKAY;
        end else if (rd_expired) begin
          rdata_q <= '0;
          rresp_q <= AXI_RESP_SLVERR;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_to_cmd_unit.sv
// ---------------------------------------------------------------
// tb_axi_lite_to_cmd_unit: directed vector bench for the AXI-Lite to
// command bridge; covers AXI_CMD_TIMEOUT_EN when defined. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_axi_lite_to_cmd_unit;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [7:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [7:0]  wr_addr_out;
  logic [31:0] wr_data_out;
  logic [3:0]  wr_strb_out;
  logic        wr_enable_out;
  logic        wr_done_in = 1'b0;
  logic [7:0]  rd_addr_out;
  logic        rd_enable_out;
  logic [31:0] rd_data_in = '0;
  logic        rd_done_in = 1'b0;
  logic        wr_busy_out;
  logic        rd_busy_out;

  axi_lite_to_cmd_unit #(
    .ADDR_W      (8),
    .DATA_W      (32),
    .TIMEOUT_CYC (16)
  ) dut (
    .sys_clk       (sys_clk),
    .reset_n       (reset_n),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .wr_addr_out   (wr_addr_out),
    .wr_data_out   (wr_data_out),
    .wr_strb_out   (wr_strb_out),
    .wr_enable_out (wr_enable_out),
    .wr_done_in    (wr_done_in),
    .rd_addr_out   (rd_addr_out),
    .rd_enable_out (rd_enable_out),
    .rd_data_in    (rd_data_in),
    .rd_done_in    (rd_done_in),
    .wr_busy_out   (wr_busy_out),
    .rd_busy_out   (rd_busy_out)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          is_rd;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[5];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic run_write(input vec_t v);
    cyc();
    s_axi_awvalid = 1'b1; s_axi_awaddr = v.addr;
    s_axi_wvalid  = 1'b1; s_axi_wdata  = v.data; s_axi_wstrb = v.strb;
    settle();
    chk("w_awready", s_axi_awready, 1);
    chk("w_wready", s_axi_wready, 1);
    chk("w_en_t0", wr_enable_out, 0);
    cyc();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    settle();
    chk("w_en_t1", wr_enable_out, 1);
    chk("w_addr", wr_addr_out, v.exp_addr);
    chk("w_data", wr_data_out, v.exp_data);
    chk("w_strb", wr_strb_out, v.exp_strb);
    chk("w_busy_t1", wr_busy_out, 1);
    cyc();
    wr_done_in = 1'b1;
    settle();
    chk("w_en_t2", wr_enable_out, 0);
    chk("w_bvalid_t2", s_axi_bvalid, 0);
    chk("w_busy_t2", wr_busy_out, 1);
    cyc();
    wr_done_in = 1'b0; s_axi_bready = 1'b1;
    settle();
    chk("w_bvalid_t3", s_axi_bvalid, 1);
    chk("w_bresp", s_axi_bresp, v.exp_resp);
    cyc();
    s_axi_bready = 1'b0;
    settle();
    chk("w_bvalid_t4", s_axi_bvalid, 0);
    chk("w_busy_t4", wr_busy_out, 0);
    chk("w_awready_t4", s_axi_awready, 1);
  endtask

  task automatic run_read(input vec_t v);
    cyc();
    s_axi_arvalid = 1'b1; s_axi_araddr = v.addr;
    settle();
    chk("r_arready", s_axi_arready, 1);
    cyc();
    s_axi_arvalid = 1'b0;
    settle();
    chk("r_en_t1", rd_enable_out, 1);
    chk("r_addr", rd_addr_out, v.exp_addr);
    chk("r_busy_t1", rd_busy_out, 1);
    cyc();
    rd_done_in = 1'b1; rd_data_in = v.data;
    settle();
    chk("r_en_t2", rd_enable_out, 0);
    chk("r_rvalid_t2", s_axi_rvalid, 0);
    cyc();
    rd_done_in = 1'b0; rd_data_in = 32'h0; s_axi_rready = 1'b1;
    settle();
    chk("r_rvalid_t3", s_axi_rvalid, 1);
    chk("r_rdata", s_axi_rdata, v.exp_data);
    chk("r_rresp", s_axi_rresp, v.exp_resp);
    cyc();
    s_axi_rready = 1'b0;
    settle();
    chk("r_rvalid_t4", s_axi_rvalid, 0);
    chk("r_busy_t4", rd_busy_out, 0);
  endtask

  initial begin
    vecs[0] = '{is_rd:1'b0, addr:8'h60, data:32'h12345678, strb:4'hF,
                exp_addr:8'h60, exp_data:32'h12345678, exp_strb:4'hF, exp_resp:2'b00};
    vecs[1] = '{is_rd:1'b0, addr:8'h04, data:32'hDEADBEEF, strb:4'h0,
                exp_addr:8'h04, exp_data:32'hDEADBEEF, exp_strb:4'h0, exp_resp:2'b00};
    vecs[2] = '{is_rd:1'b1, addr:8'h0C, data:32'h5A5A5A5A, strb:4'h0,
                exp_addr:8'h0C, exp_data:32'h5A5A5A5A, exp_strb:4'h0, exp_resp:2'b00};
    vecs[3] = '{is_rd:1'b0, addr:8'hFF, data:32'h00000001, strb:4'h5,
                exp_addr:8'hFF, exp_data:32'h00000001, exp_strb:4'h5, exp_resp:2'b00};
    vecs[4] = '{is_rd:1'b1, addr:8'hFF, data:32'hC3C3C3C3, strb:4'h0,
                exp_addr:8'hFF, exp_data:32'hC3C3C3C3, exp_strb:4'h0, exp_resp:2'b00};

    // Reset state
    cyc(); cyc();
    settle();
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_wr_en", wr_enable_out, 0);
    chk("rst_rd_en", rd_enable_out, 0);
    chk("rst_busy", {30'h0, wr_busy_out, rd_busy_out}, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_wr_addr", wr_addr_out, 0);
    chk("rst_wr_data", wr_data_out, 0);
    chk("rst_strb_rdaddr", {wr_strb_out, rd_addr_out}, 0);
    reset_n = 1'b1;
    cyc(); cyc();

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].is_rd) run_read(vecs[i]);
      else               run_write(vecs[i]);
    end

    // W three cycles ahead of AW
    cyc();
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'h3;
    settle();
    chk("wfirst_wready", s_axi_wready, 1);
    cyc();
    s_axi_wvalid = 1'b0;
    settle();
    chk("wfirst_wready_held", s_axi_wready, 0);
    chk("wfirst_awready", s_axi_awready, 1);
    chk("wfirst_en_a", wr_enable_out, 0);
    cyc();
    settle();
    chk("wfirst_en_b", wr_enable_out, 0);
    cyc();
    s_axi_awvalid = 1'b1; s_axi_awaddr = 8'h04;
    settle();
    chk("wfirst_en_c", wr_enable_out, 0);
    cyc();
    s_axi_awvalid = 1'b0;
    settle();
    chk("wfirst_en", wr_enable_out, 1);
    chk("wfirst_addr", wr_addr_out, 32'h04);
    chk("wfirst_data", wr_data_out, 32'hCAFEF00D);
    chk("wfirst_strb", wr_strb_out, 4'h3);
    cyc();
    wr_done_in = 1'b1;
    settle();
    chk("wfirst_en_off", wr_enable_out, 0);
    cyc();
    wr_done_in = 1'b0; s_axi_bready = 1'b1;
    settle();
    chk("wfirst_bvalid", s_axi_bvalid, 1);
    cyc();
    s_axi_bready = 1'b0;
    settle();
    chk("wfirst_bvalid_off", s_axi_bvalid, 0);

    // Read with slow done, done coincident with enable ignored, rready stall
    cyc();
    s_axi_arvalid = 1'b1; s_axi_araddr = 8'h0C;
    settle();
    cyc();
    s_axi_arvalid = 1'b0;
    rd_done_in = 1'b1; rd_data_in = 32'h11111111;
    settle();
    chk("slow_en", rd_enable_out, 1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      rd_done_in = 1'b0; rd_data_in = 32'h0;
      settle();
      chk("slow_rvalid_wait", s_axi_rvalid, 0);
      chk("slow_busy_wait", rd_busy_out, 1);
    end
    cyc();
    rd_done_in = 1'b1; rd_data_in = 32'hA5A5A5A5;
    settle();
    chk("slow_rvalid_pre", s_axi_rvalid, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      rd_done_in = 1'b0; rd_data_in = 32'hFFFF0000;
      settle();
      chk("slow_rvalid_stall", s_axi_rvalid, 1);
      chk("slow_rdata_stall", s_axi_rdata, 32'hA5A5A5A5);
      chk("slow_rresp_stall", s_axi_rresp, 0);
    end
    s_axi_rready = 1'b1;
    cyc();
    s_axi_rready = 1'b0;
    settle();
    chk("slow_rvalid_off", s_axi_rvalid, 0);

    // Concurrent write and read: write wins, read waits for B handshake
    cyc();
    s_axi_awvalid = 1'b1; s_axi_awaddr = 8'h10;
    s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'h0000BEEF; s_axi_wstrb = 4'hF;
    s_axi_arvalid = 1'b1; s_axi_araddr = 8'h20;
    settle();
    chk("cc_arready", s_axi_arready, 1);
    cyc();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    settle();
    chk("cc_wr_en", wr_enable_out, 1);
    chk("cc_rd_en_t1", rd_enable_out, 0);
    cyc();
    wr_done_in = 1'b1;
    settle();
    chk("cc_rd_en_t2", rd_enable_out, 0);
    cyc();
    wr_done_in = 1'b0; s_axi_bready = 1'b1;
    settle();
    chk("cc_bvalid", s_axi_bvalid, 1);
    chk("cc_bresp", s_axi_bresp, 0);
    chk("cc_rd_en_t3", rd_enable_out, 0);
    cyc();
    s_axi_bready = 1'b0;
    settle();
    chk("cc_rd_en_t4", rd_enable_out, 1);
    chk("cc_rd_addr", rd_addr_out, 32'h20);
    cyc();
    rd_done_in = 1'b1; rd_data_in = 32'h0BADBEEF;
    settle();
    cyc();
    rd_done_in = 1'b0; s_axi_rready = 1'b1;
    settle();
    chk("cc_rvalid", s_axi_rvalid, 1);
    chk("cc_rresp", s_axi_rresp, 0);
    chk("cc_rdata", s_axi_rdata, 32'h0BADBEEF);
    cyc();
    s_axi_rready = 1'b0;
    settle();
    chk("cc_rvalid_off", s_axi_rvalid, 0);

`ifdef AXI_CMD_TIMEOUT_EN
    begin : to_seq
      int n;
      bit seen;
      cyc();
      s_axi_arvalid = 1'b1; s_axi_araddr = 8'h30;
      settle();
      cyc();
      s_axi_arvalid = 1'b0;
      settle();
      chk("to_en", rd_enable_out, 1);
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
        cyc();
        settle();
        n++;
        if (s_axi_rvalid) seen = 1'b1;
      end
      chk("to_latency", n, 17);
      chk("to_rresp", s_axi_rresp, 2'b10);
      chk("to_rdata", s_axi_rdata, 0);
      rd_done_in = 1'b1; rd_data_in = 32'hFFFFFFFF;
      cyc();
      rd_done_in = 1'b0;
      settle();
      chk("to_late_rvalid", s_axi_rvalid, 1);
      chk("to_late_rdata", s_axi_rdata, 0);
      chk("to_late_rresp", s_axi_rresp, 2'b10);
      s_axi_rready = 1'b1;
      cyc();
      s_axi_rready = 1'b0;
      rd_done_in = 1'b1;
      settle();
      cyc();
      rd_done_in = 1'b0;
      settle();
      chk("to_idle_rvalid", s_axi_rvalid, 0);
      chk("to_idle_busy", rd_busy_out, 0);
    end
`endif

    // Reset during W_WAIT
    cyc();
    s_axi_awvalid = 1'b1; s_axi_awaddr = 8'h44;
    s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'h55AA55AA; s_axi_wstrb = 4'hF;
    settle();
    cyc();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    settle();
    chk("rw_en", wr_enable_out, 1);
    cyc();
    reset_n = 1'b0;
    settle();
    chk("rw_busy", wr_busy_out, 0);
    chk("rw_addr", wr_addr_out, 0);
    chk("rw_data", wr_data_out, 0);
    chk("rw_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
    chk("rw_rdata", s_axi_rdata, 0);
    cyc();
    reset_n = 1'b1; wr_done_in = 1'b1;
    settle();
    cyc();
    wr_done_in = 1'b0;
    settle();
    chk("rw_bvalid", s_axi_bvalid, 0);
    chk("rw_busy_after", wr_busy_out, 0);
    chk("rw_en_after", wr_enable_out, 0);
    run_write(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
